// File: rtl/dcm_ps_responder_pkg.sv
// Shared definitions for the DCM variable-phase-shift handshake.
// The initiator imports the same package, so both ends agree on the
// status bit layout and the default phase range.
package dcm_ps_responder_pkg;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ps_state_e;

  // Bit positions inside the 8-bit status word
  localparam int STAT_OVF  = 0;
  localparam int STAT_PERR = 7;

  // Default phase range, shared with the initiator
  localparam int PS_MAX_DEF = 255;
  localparam int CNT_W_DEF  = 9;

endpackage

// File: rtl/dcm_ps_responder.sv
// Responder end of the DCM PSEN/PSINCDEC/PSDONE handshake.
// It keeps a signed phase count clamped to +/-PS_MAX and steps a tap-based
// delay element once per accepted request. Each accepted request answers
// with a single PSDONE pulse, PS_LATENCY cycles after the request.
module dcm_ps_responder
  import dcm_ps_responder_pkg::*;
#(
  parameter int PS_MAX     = PS_MAX_DEF,
  parameter int PS_INIT    = 0,
  parameter int PS_LATENCY = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    locked_i,
  input  logic                    dcm_psen_i,
  input  logic                    dcm_psincdec_i,
  output logic                    dcm_psdone_o,
  output logic [7:0]              dcm_status_o,
  output logic signed [CNT_W-1:0] phase_o,
  output logic                    tap_ce_o,
  output logic                    tap_inc_o,
  output logic                    busy_o
);

  // Catch parameter sets that would let the count wrap or break the countdown
  if (PS_MAX < 0 || PS_MAX > (2 ** (CNT_W - 1)) - 1) begin : g_bad_max
    $error("dcm_ps_responder: PS_MAX does not fit a signed CNT_W-bit count");
  end
  if (PS_INIT > PS_MAX || PS_INIT < -PS_MAX) begin : g_bad_init
    $error("dcm_ps_responder: PS_INIT lies outside +/-PS_MAX");
  end
  if (PS_LATENCY < 1 || PS_LATENCY > 15) begin : g_bad_lat
    $error("dcm_ps_responder: PS_LATENCY must be 1..15");
  end

  localparam logic signed [CNT_W-1:0] PH_MAX  = CNT_W'(PS_MAX);
  localparam logic signed [CNT_W-1:0] PH_MIN  = CNT_W'(-PS_MAX);
  localparam logic signed [CNT_W-1:0] PH_INIT = CNT_W'(PS_INIT);
  localparam logic signed [CNT_W-1:0] PH_ONE  = CNT_W'(1);
  localparam logic [3:0]              LAT_LD  = 4'(PS_LATENCY - 1);

  ps_state_e               state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic signed [CNT_W-1:0] phase_q, phase_d;
  logic                    ovf_q, ovf_d;
  logic                    perr_q, perr_d;
  logic                    tap_ce_q, tap_ce_d;
  logic                    tap_inc_q, tap_inc_d;
  logic                    at_limit;

  // Register every piece of state; reset drops any transaction in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= PH_INIT;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      tap_ce_q  <= 1'b0;
      tap_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      tap_ce_q  <= tap_ce_d;
      tap_inc_q <= tap_inc_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, one DONE cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    ovf_d     = ovf_q;
    perr_d    = perr_q;
    tap_ce_d  = 1'b0;
    tap_inc_d = 1'b0;
    at_limit  = dcm_psincdec_i ? (phase_q == PH_MAX) : (phase_q == PH_MIN);
    unique case (state_q)
      IDLE: begin
        if (dcm_psen_i && locked_i) begin
          if (at_limit) begin
            ovf_d = 1'b1;
          end else begin
            phase_d   = dcm_psincdec_i ? phase_q + PH_ONE : phase_q - PH_ONE;
            ovf_d     = 1'b0;
            tap_ce_d  = 1'b1;
            tap_inc_d = dcm_psincdec_i;
          end
          if (PS_LATENCY == 1) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_LD;
          end
        end
      end
      BUSY: begin
        if (dcm_psen_i) perr_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (dcm_psen_i) perr_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state and flags
  always_comb begin
    dcm_status_o            = '0;
    dcm_status_o[STAT_OVF]  = ovf_q;
    dcm_status_o[STAT_PERR] = perr_q;
    dcm_psdone_o            = (state_q == DONE);
    busy_o                  = (state_q != IDLE);
    phase_o                 = phase_q;
    tap_ce_o                = tap_ce_q;
    tap_inc_o               = tap_inc_q;
  end

endmodule

// File: tb/tb_dcm_ps_responder.sv
// Directed bench for dcm_ps_responder. Four instances cover the main
// parameter corners: centred count, near +limit, near -limit and latency 1.
// Expected PSDONE events are queued at request time and consumed by a monitor.
module tb_dcm_ps_responder;

  localparam int PS_MAX = 255;
  localparam int NINST  = 4;
  localparam int INIT_TAB [NINST] = '{0, 254, -254, 0};
  localparam int LAT_TAB  [NINST] = '{4, 4, 4, 1};

  typedef struct {
    int   inst;
    int   due;
    int   phase;
    logic ovf;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              locked;
  logic              psincdec;
  logic [NINST-1:0]  psen_v;
  logic [NINST-1:0]  psdone_v;
  logic [NINST-1:0]  tap_ce_v;
  logic [NINST-1:0]  tap_inc_v;
  logic [NINST-1:0]  busy_v;
  logic [7:0]        status_v [NINST];
  logic signed [8:0] phase_v  [NINST];

  exp_t       sb [$];
  int         cyc;
  int         n_cmp;
  int         n_err;
  int         exp_phase [NINST];
  logic [NINST-1:0] exp_ovf;
  logic [NINST-1:0] exp_perr;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    dcm_ps_responder #(
      .PS_MAX    (PS_MAX),
      .PS_INIT   (INIT_TAB[g]),
      .PS_LATENCY(LAT_TAB[g]),
      .CNT_W     (9)
    ) u_dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .locked_i      (locked),
      .dcm_psen_i    (psen_v[g]),
      .dcm_psincdec_i(psincdec),
      .dcm_psdone_o  (psdone_v[g]),
      .dcm_status_o  (status_v[g]),
      .phase_o       (phase_v[g]),
      .tap_ce_o      (tap_ce_v[g]),
      .tap_inc_o     (tap_inc_v[g]),
      .busy_o        (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < NINST; k++) exp_phase[k] = INIT_TAB[k];
    exp_ovf  = '0;
    exp_perr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One accepted request; returns in the cycle after the tap_ce cycle
  task automatic applyStimulus(input int k, input logic dir);
    exp_t item;
    logic blocked;
    blocked = dir ? (exp_phase[k] == PS_MAX) : (exp_phase[k] == -PS_MAX);
    if (blocked) exp_ovf[k] = 1'b1;
    else begin
      exp_phase[k] += dir ? 1 : -1;
      exp_ovf[k] = 1'b0;
    end
    @(negedge clk);
    psen_v[k] = 1'b1;
    psincdec  = dir;
    @(posedge clk);
    #1;
    psen_v[k] = 1'b0;
    checkOutput($sformatf("tap_ce[%0d]", k), tap_ce_v[k], !blocked);
    if (!blocked) checkOutput($sformatf("tap_inc[%0d]", k), tap_inc_v[k], dir);
    checkOutput($sformatf("busy[%0d]", k), busy_v[k], 1'b1);
    checkOutput($sformatf("phase[%0d]", k), phase_v[k], exp_phase[k]);
    checkOutput($sformatf("ovf[%0d]", k), status_v[k][0], exp_ovf[k]);
    item.inst  = k;
    item.due   = cyc + LAT_TAB[k] - 1;
    item.phase = exp_phase[k];
    item.ovf   = exp_ovf[k];
    sb.push_back(item);
    @(posedge clk);
    #1;
    checkOutput($sformatf("tap_ce_single[%0d]", k), tap_ce_v[k], 1'b0);
  endtask

  // Raw psen pulse with no expected completion (protocol-error stimulus)
  task automatic pulseRaw(input int k);
    exp_perr[k] = 1'b1;
    @(negedge clk);
    psen_v[k] = 1'b1;
    @(posedge clk);
    #1;
    psen_v[k] = 1'b0;
  endtask

  // Monitor: every PSDONE must match a queued expectation due this cycle
  always @(negedge clk) begin
    for (int k = 0; k < NINST; k++) begin
      int idx;
      idx = -1;
      for (int j = sb.size() - 1; j >= 0; j--)
        if (sb[j].inst == k && sb[j].due <= cyc) idx = j;
      if (idx >= 0 || psdone_v[k] !== 1'b0) begin
        checkOutput($sformatf("psdone[%0d]@%0d", k, cyc), psdone_v[k], idx >= 0);
        if (idx >= 0) begin
          checkOutput($sformatf("done_phase[%0d]", k), phase_v[k], sb[idx].phase);
          checkOutput($sformatf("done_status[%0d]", k), status_v[k],
                      {exp_perr[k], 6'b0, sb[idx].ovf});
          checkOutput($sformatf("done_busy[%0d]", k), busy_v[k], 1'b1);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    reset = 1'b1; locked = 1'b1; psincdec = 1'b0; psen_v = '0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of every instance
    for (int k = 0; k < NINST; k++) begin
      checkOutput($sformatf("rst_phase[%0d]", k), phase_v[k], INIT_TAB[k]);
      checkOutput($sformatf("rst_status[%0d]", k), status_v[k], 0);
      checkOutput($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
      checkOutput($sformatf("rst_tap_ce[%0d]", k), tap_ce_v[k], 0);
    end

    // Three increments spaced 8 cycles apart
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1);
      idle(6);
    end
    checkOutput("phase_after_incs", phase_v[0], 3);

    // Positive limit: 254 -> 255, then blocked, then back down
    applyStimulus(1, 1'b1); idle(6);
    applyStimulus(1, 1'b1); idle(6);
    checkOutput("pos_limit_phase", phase_v[1], 255);
    applyStimulus(1, 1'b0); idle(6);
    checkOutput("pos_limit_recover", status_v[1], 0);

    // Negative limit mirror
    applyStimulus(2, 1'b0); idle(6);
    applyStimulus(2, 1'b0); idle(6);
    checkOutput("neg_limit_phase", phase_v[2], -255);
    applyStimulus(2, 1'b1); idle(6);
    checkOutput("neg_limit_recover", status_v[2], 0);

    // Requests while unlocked are ignored silently
    @(negedge clk);
    locked = 1'b0; psen_v[0] = 1'b1; psincdec = 1'b1;
    @(posedge clk);
    #1;
    psen_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("unlocked_busy", busy_v[0], 0);
      idle(1);
    end
    checkOutput("unlocked_phase", phase_v[0], 3);
    checkOutput("unlocked_status", status_v[0], 0);
    locked = 1'b1;

    // Losing lock mid-transaction still completes it
    applyStimulus(0, 1'b1);
    locked = 1'b0;
    idle(6);
    locked = 1'b1;
    checkOutput("lock_drop_phase", phase_v[0], 4);

    // Second psen two cycles after the first is a protocol error
    applyStimulus(0, 1'b0);
    pulseRaw(0);
    idle(6);
    checkOutput("perr_phase", phase_v[0], 3);
    checkOutput("perr_status", status_v[0], 8'h80);
    applyStimulus(0, 1'b1); idle(6);
    checkOutput("perr_sticky", status_v[0][7], 1'b1);

    // Latency 1: psdone the cycle after psen
    applyStimulus(3, 1'b1); idle(4);
    checkOutput("lat1_phase", phase_v[3], 1);

    // Reset in the second busy cycle drops the transaction
    applyStimulus(0, 1'b1);
    reset = 1'b1;
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == 0) sb.delete(j);
    resetModel();
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midrst_busy", busy_v[0], 0);
    checkOutput("midrst_phase", phase_v[0], 0);
    checkOutput("midrst_tap_ce", tap_ce_v[0], 0);
    checkOutput("midrst_status", status_v[0], 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("midrst_no_done", psdone_v[0], 0);
      idle(1);
    end

    idle(4);
    checkOutput("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
